// File: rtl/core_pkg.sv
// Shared decode types for the RV32I core: opcodes, ALU operation encoding and
// the control bundle carried down the pipeline.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e aluOp;
        logic    aluSrcImm;
        logic    pcSrcA;
        logic    memRead;
        logic    memWrite;
        logic    regWrite;
        logic    memToReg;
        logic    branch;
        logic    jump;
        logic    jalr;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // funct7[5] selects SUB only for R-type; for shifts it selects arithmetic in both formats
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
        alu_op_e op;
        case (f3)
            3'd0:    op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle between the decode stage and its neighbours: fetch input, write-back
// port, flush request, stall return and the ID/EX pipeline register.
interface id_stage_if #(
    parameter int XLEN = 32
);
    import core_pkg::*;

    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_reg;
    logic            EXE_jumpBranch;
    logic            WB_regWrite;
    logic [4:0]      WB_rd;
    logic [XLEN-1:0] WB_wdata;
    logic            ID_hazardStall;
    logic [XLEN-1:0] ID_EX_pc;
    logic [XLEN-1:0] ID_EX_rs1Data;
    logic [XLEN-1:0] ID_EX_rs2Data;
    logic [XLEN-1:0] ID_EX_imm;
    logic [4:0]      ID_EX_rs1;
    logic [4:0]      ID_EX_rs2;
    logic [4:0]      ID_EX_rd;
    logic [2:0]      ID_EX_funct3;
    ctrl_t           ID_EX_ctrl;

    modport master (
        output instruction, pc_reg, EXE_jumpBranch, WB_regWrite, WB_rd, WB_wdata,
        input  ID_hazardStall, ID_EX_pc, ID_EX_rs1Data, ID_EX_rs2Data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_funct3, ID_EX_ctrl
    );

    modport slave (
        input  instruction, pc_reg, EXE_jumpBranch, WB_regWrite, WB_rd, WB_wdata,
        output ID_hazardStall, ID_EX_pc, ID_EX_rs1Data, ID_EX_rs2Data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_funct3, ID_EX_ctrl
    );

endinterface

// File: rtl/reg_file.sv
// 2-read/1-write architectural register file with x0 hardwired to zero and a
// write-through bypass so a same-cycle write-back is seen by decode.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_live;

    assign w_wr_live = i_we && (i_waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (w_wr_live && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (w_wr_live && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, immediate generation, register read,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);

    localparam int RW = $clog2(NREG);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_f7b5;
    logic [31:0]     w_inst;
    logic [XLEN-1:0] w_rs1Data;
    logic [XLEN-1:0] w_rs2Data;
    logic [XLEN-1:0] w_imm;
    ctrl_t           w_ctrl;
    logic            w_rs1Used;
    logic            w_rs2Used;
    logic            w_raw;
    logic            w_stall;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1Data;
    logic [XLEN-1:0] r_rs2Data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    ctrl_t           r_ctrl;

    assign w_inst   = bus.instruction;
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_f7b5   = w_inst[30];

    reg_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1[RW-1:0]),
        .i_raddr2 (w_rs2[RW-1:0]),
        .o_rdata1 (w_rs1Data),
        .o_rdata2 (w_rs2Data),
        .i_we     (bus.WB_regWrite),
        .i_waddr  (bus.WB_rd[RW-1:0]),
        .i_wdata  (bus.WB_wdata)
    );

    always_comb begin
        w_ctrl    = '0;
        w_imm     = '0;
        w_rs1Used = 1'b0;
        w_rs2Used = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.aluOp    = alu_decode(w_funct3, w_f7b5, 1'b1);
                w_ctrl.regWrite = 1'b1;
                w_rs1Used       = 1'b1;
                w_rs2Used       = 1'b1;
            end
            OP_IMM: begin
                w_ctrl.aluOp     = alu_decode(w_funct3, w_f7b5, 1'b0);
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_rs1Used        = 1'b1;
                w_imm            = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OP_LOAD: begin
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.memRead   = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.memToReg  = 1'b1;
                w_rs1Used        = 1'b1;
                w_imm            = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OP_STORE: begin
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.memWrite  = 1'b1;
                w_rs1Used        = 1'b1;
                w_rs2Used        = 1'b1;
                w_imm            = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            OP_BRANCH: begin
                w_ctrl.aluOp  = ALU_SUB;
                w_ctrl.branch = 1'b1;
                w_rs1Used     = 1'b1;
                w_rs2Used     = 1'b1;
                w_imm         = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25],
                                 w_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.pcSrcA    = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_imm            = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20],
                                    w_inst[30:21], 1'b0};
            end
            OP_JALR: begin
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.pcSrcA    = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.jalr      = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_rs1Used        = 1'b1;
                w_imm            = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OP_LUI: begin
                w_ctrl.aluOp     = ALU_PASSB;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_imm            = {w_inst[31:12], 12'h000};
            end
            OP_AUIPC: begin
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.pcSrcA    = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_imm            = {w_inst[31:12], 12'h000};
            end
            default: ;
        endcase
        if (w_rd == '0) begin
            w_ctrl.regWrite = 1'b0;
        end
    end

    // Only a load already in ID/EX can produce data too late for forwarding
    assign w_raw = r_ctrl.memRead && (r_rd != '0) &&
                   ((w_rs1Used && (w_rs1 == r_rd)) || (w_rs2Used && (w_rs2 == r_rd)));
    assign w_stall = w_raw && !bus.EXE_jumpBranch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_rs1Data <= '0;
            r_rs2Data <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_ctrl    <= '0;
        end else if (bus.EXE_jumpBranch || w_stall) begin
            r_pc      <= '0;
            r_rs1Data <= '0;
            r_rs2Data <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_ctrl    <= '0;
        end else begin
            r_pc      <= bus.pc_reg;
            r_rs1Data <= w_rs1Data;
            r_rs2Data <= w_rs2Data;
            r_imm     <= w_imm;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_funct3  <= w_funct3;
            r_ctrl    <= w_ctrl;
        end
    end

    assign bus.ID_hazardStall = w_stall;
    assign bus.ID_EX_pc       = r_pc;
    assign bus.ID_EX_rs1Data  = r_rs1Data;
    assign bus.ID_EX_rs2Data  = r_rs2Data;
    assign bus.ID_EX_imm      = r_imm;
    assign bus.ID_EX_rs1      = r_rs1;
    assign bus.ID_EX_rs2      = r_rs2;
    assign bus.ID_EX_rd       = r_rd;
    assign bus.ID_EX_funct3   = r_funct3;
    assign bus.ID_EX_ctrl     = r_ctrl;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage RV32I core. It sits directly downstream of the fetch stage and consumes its `instruction`/`pc_reg` pair. It decodes the instruction, reads the 32x32 register file (written back from WB), generates the immediate, and detects load-use hazards. It drives the ID/EX pipeline register consumed by the execute stage and returns `ID_hazardStall` to fetch.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers (x0 hardwired to zero)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `instruction`  in  32  instruction from fetch; 0 denotes a bubble
- `pc_reg`  in  32  PC of `instruction`
- `EXE_jumpBranch`  in  1  taken jump/branch resolved in EXE; flush request
- `WB_regWrite`  in  1  write-back enable
- `WB_rd`  in  5  write-back destination
- `WB_wdata`  in  32  write-back data
- `ID_hazardStall`  out  1  load-use stall request to fetch (combinational)
- `ID_EX_pc`  out  32  registered PC
- `ID_EX_rs1Data`, `ID_EX_rs2Data`  out  32  registered operands
- `ID_EX_imm`  out  32  registered sign-extended immediate
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd`  out  5  registered register indices (for EXE forwarding)
- `ID_EX_funct3`  out  3  registered funct3
- `ID_EX_ctrl`  out  `CTRL_W`  registered control bundle (`ctrl_t`)

## Operation
- Opcode decode covers R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC. Any other opcode, including the all-zero bubble, produces an all-zero `ctrl_t` (NOP).
- `ctrl_t` fields:
  - `aluOp[3:0]`, derived from opcode, funct3 and funct7[5]; funct7[5] is used only for R-type, and for I-type SRAI.
  - `aluSrcImm`, `pcSrcA` (AUIPC/JAL/JALR).
  - `memRead`, `memWrite`, `regWrite`, `memToReg`.
  - `branch`, `jump`, `jalr`.
- `regWrite` is forced to 0 when rd=x0.
- Immediate formats:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'h0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - All formats except U are sign-extended from bit 31.
- Register file:
  - Two asynchronous read ports and one write port on posedge `clk`.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: a read with index == `WB_rd` while `WB_regWrite`=1 and `WB_rd`≠0 returns `WB_wdata` in the same cycle.
- Source-register use:
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
- Load-use hazard: raw = `ID_EX_ctrl.memRead` ∧ `ID_EX_rd`≠0 ∧ ((rs1 used ∧ rs1==`ID_EX_rd`) ∨ (rs2 used ∧ rs2==`ID_EX_rd`)).
- `ID_hazardStall` = raw ∧ ¬`EXE_jumpBranch`.
- ID/EX update priority, evaluated each posedge:
  1. `EXE_jumpBranch`: load a bubble (all outputs 0).
  2. `ID_hazardStall`: load a bubble.
  3. Otherwise: load the decoded fields.
- There is no hold state. Fetch replays the stalled instruction, and ID re-decodes it in the next cycle.

## Timing
- Reset (asynchronous assert) drives every `ID_EX_*` output to 0. `ID_hazardStall` is 0 while in reset because `ID_EX_ctrl`=0.
- Register file contents are cleared to 0 on reset.
- Latency is one cycle from `instruction` valid to `ID_EX_*` valid.
- `ID_hazardStall` is combinational in the same cycle as the offending instruction. It asserts for exactly one cycle per load-use pair, because the following ID/EX contents are a bubble with `memRead`=0.
- A flush coinciding with a stall takes the flush; the stall is suppressed.
- A WB write in cycle N is visible to a decode in cycle N via the bypass.

## Structure
- Package `core_pkg`:
  - `ctrl_t` packed struct and `CTRL_W`.
  - Opcode localparams (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`).
  - `aluOp` encoding enum `alu_op_e`.
- Sub-module `reg_file`: 2R1W, bypass and x0 handling inside. Decode, immediate generation, hazard logic and the ID/EX register stay in `id_stage`.

## Test plan
- Reset: assert `rst` mid-operation with a live instruction → all `ID_EX_*`=0 and `ID_hazardStall`=0 immediately; after release x1 reads 0.
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2` → `ID_hazardStall`=1 for one cycle; ID/EX gets a bubble, then the add with rs1=5. Repeat with rd=x0 → no stall.
- Flush: `EXE_jumpBranch`=1 while `addi x3,x0,7` is in ID → next `ID_EX_ctrl`=0 and `ID_EX_pc`=0; a simultaneous load-use condition gives `ID_hazardStall`=0.
- Bypass: WB writes x7=0xDEADBEEF while decoding `add x8,x7,x7` → `ID_EX_rs1Data`=`ID_EX_rs2Data`=0xDEADBEEF next cycle; a WB write to x0 leaves x0 at 0.
- Immediates:
  - `beq` with offset −8 (inst 0xFE000CE3) → `ID_EX_imm`=0xFFFFFFF8.
  - `lui x1,0x12345` → 0x12345000.
  - `jal` with offset +2048 → 0x00000800.
- Illegal/bubble: instruction 0x00000000 and opcode 0x7F → `ID_EX_ctrl`=0; SRAI vs SRLI yield distinct `aluOp`.
